// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the common-data-bus arbiter: ROB geometry and the
// source IDs that appear on cdb_src.
package cdb_arbiter_pkg;

  localparam int ROB_POS_WID = 4;
  localparam int ROB_SIZE    = 1 << ROB_POS_WID;

  typedef enum logic {
    CDB_SRC_ALU = 1'b0,
    CDB_SRC_LSB = 1'b1
  } cdb_src_e;

  // Payload widths of the two per-source queues.
  function automatic int alu_entry_w(input int rob_w);
    return rob_w + 65;  // rob_pos + val + pc + jump
  endfunction

  function automatic int lsb_entry_w(input int rob_w);
    return rob_w + 32;  // rob_pos + val
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Bundle of the arbiter's control, source handshakes and broadcast bus.
// master = the side driving results in (execution units / ROB control),
// slave  = the arbiter itself.
interface cdb_arbiter_if #(parameter int ROB_W = 4);

  logic             rdy;
  logic             rollback;

  logic             alu_valid;
  logic             alu_ready;
  logic [ROB_W-1:0] alu_rob_pos;
  logic [31:0]      alu_val;
  logic             alu_jump;
  logic [31:0]      alu_pc;

  logic             lsb_valid;
  logic             lsb_ready;
  logic [ROB_W-1:0] lsb_rob_pos;
  logic [31:0]      lsb_val;

  logic             cdb_valid;
  logic             cdb_src;
  logic [ROB_W-1:0] cdb_rob_pos;
  logic [31:0]      cdb_val;
  logic             cdb_jump;
  logic [31:0]      cdb_pc;

  modport master (
    output rdy, rollback,
    output alu_valid, alu_rob_pos, alu_val, alu_jump, alu_pc,
    input  alu_ready,
    output lsb_valid, lsb_rob_pos, lsb_val,
    input  lsb_ready,
    input  cdb_valid, cdb_src, cdb_rob_pos, cdb_val, cdb_jump, cdb_pc
  );

  modport slave (
    input  rdy, rollback,
    input  alu_valid, alu_rob_pos, alu_val, alu_jump, alu_pc,
    output alu_ready,
    input  lsb_valid, lsb_rob_pos, lsb_val,
    output lsb_ready,
    output cdb_valid, cdb_src, cdb_rob_pos, cdb_val, cdb_jump, cdb_pc
  );

endinterface

// File: rtl/cdb_arbiter_result_fifo.sv
// Small FIFO holding completed results of one source. en=0 freezes every
// register; flush empties the queue. Push while full and pop while empty
// are ignored.
module result_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_cnt;

  logic w_push;
  logic w_pop;
  logic w_act;

  assign full   = (r_cnt == FULL_CNT);
  assign empty  = (r_cnt == '0);
  assign w_act  = en && !flush;
  assign w_push = w_act && push && !full;
  assign w_pop  = w_act && pop && !empty;
  assign dout   = r_mem[r_rd_ptr];

  // Pointer/count bookkeeping; pointers wrap modulo DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else if (en) begin
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_cnt    <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        case ({w_push, w_pop})
          2'b10:   r_cnt <= r_cnt + 1'b1;
          2'b01:   r_cnt <= r_cnt - 1'b1;
          default: r_cnt <= r_cnt;
        endcase
      end
    end
  end

  // Storage needs no reset: entries are only read once counted valid.
  always_ff @(posedge clk) begin
    if (!rst && w_push) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: per-source result queues for ALU and LSB, a
// round-robin grant between them, and a registered single-result broadcast.
// Priority: rst > !rdy > rollback > normal operation.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int ROB_W      = ROB_POS_WID
) (
  input logic          clk,
  input logic          rst,
  cdb_arbiter_if.slave bus
);

  localparam int ALU_W = alu_entry_w(ROB_W);
  localparam int LSB_W = lsb_entry_w(ROB_W);

  logic [ALU_W-1:0] w_alu_din, w_alu_dout;
  logic [LSB_W-1:0] w_lsb_din, w_lsb_dout;
  logic             w_alu_full, w_alu_empty;
  logic             w_lsb_full, w_lsb_empty;
  logic             w_gnt_alu, w_gnt_lsb;

  logic             r_valid;
  cdb_src_e         r_src;
  logic [ROB_W-1:0] r_rob_pos;
  logic [31:0]      r_val;
  logic             r_jump;
  logic [31:0]      r_pc;
  cdb_src_e         r_last_grant;

  assign w_alu_din = {bus.alu_jump, bus.alu_pc, bus.alu_val, bus.alu_rob_pos};
  assign w_lsb_din = {bus.lsb_val, bus.lsb_rob_pos};

  // Ready comes from registered occupancy only, never from a same-cycle pop.
  assign bus.alu_ready = !w_alu_full;
  assign bus.lsb_ready = !w_lsb_full;

  // Round-robin on queue contents: a lone non-empty source wins, otherwise
  // the source that did not win last time.
  assign w_gnt_alu = !w_alu_empty && (w_lsb_empty || r_last_grant == CDB_SRC_LSB);
  assign w_gnt_lsb = !w_lsb_empty && !w_gnt_alu;

  result_fifo #(.W(ALU_W), .DEPTH(FIFO_DEPTH)) u_alu_q (
    .clk   (clk),
    .rst   (rst),
    .en    (bus.rdy),
    .flush (bus.rollback),
    .push  (bus.alu_valid),
    .pop   (w_gnt_alu),
    .din   (w_alu_din),
    .dout  (w_alu_dout),
    .full  (w_alu_full),
    .empty (w_alu_empty)
  );

  result_fifo #(.W(LSB_W), .DEPTH(FIFO_DEPTH)) u_lsb_q (
    .clk   (clk),
    .rst   (rst),
    .en    (bus.rdy),
    .flush (bus.rollback),
    .push  (bus.lsb_valid),
    .pop   (w_gnt_lsb),
    .din   (w_lsb_din),
    .dout  (w_lsb_dout),
    .full  (w_lsb_full),
    .empty (w_lsb_empty)
  );

  // Broadcast register and round-robin state; payload holds when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid      <= 1'b0;
      r_src        <= CDB_SRC_ALU;
      r_rob_pos    <= '0;
      r_val        <= '0;
      r_jump       <= 1'b0;
      r_pc         <= '0;
      r_last_grant <= CDB_SRC_LSB;
    end else if (bus.rdy) begin
      if (bus.rollback) begin
        r_valid <= 1'b0;
      end else if (w_gnt_alu) begin
        r_valid      <= 1'b1;
        r_src        <= CDB_SRC_ALU;
        r_rob_pos    <= w_alu_dout[ROB_W-1:0];
        r_val        <= w_alu_dout[ROB_W +: 32];
        r_pc         <= w_alu_dout[ROB_W+32 +: 32];
        r_jump       <= w_alu_dout[ALU_W-1];
        r_last_grant <= CDB_SRC_ALU;
      end else if (w_gnt_lsb) begin
        r_valid      <= 1'b1;
        r_src        <= CDB_SRC_LSB;
        r_rob_pos    <= w_lsb_dout[ROB_W-1:0];
        r_val        <= w_lsb_dout[ROB_W +: 32];
        r_pc         <= '0;
        r_jump       <= 1'b0;
        r_last_grant <= CDB_SRC_LSB;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.cdb_valid   = r_valid;
  assign bus.cdb_src     = r_src;
  assign bus.cdb_rob_pos = r_rob_pos;
  assign bus.cdb_val     = r_val;
  assign bus.cdb_jump    = r_jump;
  assign bus.cdb_pc      = r_pc;

endmodule
